chi_step: RTL

Chi (χ) nonlinear step of the Keccak-f[1600] round. It sits directly upstream of `addRc` in the round pipeline and transforms the 25×64-bit state held in the shared state RAM one plane (row) at a time, in place. When it finishes, the state is ready for the round-constant stage. The block uses the same start/ready handshake as the other round stages, so the round controller chains it directly into `addRc`.

---
 rtl/chi_step_if.sv | 43 ++++
 rtl/chi_step.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/chi_step_if.sv
// -----------------------------------------------------------------------------
// chi_step_if
//
// Bundles the round-stage handshake (start / busy / ready) and the state-RAM
// read/write port used by chi_step.
//
// Modports:
//   master : the chi_step block itself; drives the RAM strobes and the status,
//            receives start and the RAM read data.
//   slave  : the round controller plus state RAM; drives start and rd_data,
//            observes everything else.
//
// Signals:
//   start    one-cycle run request
//   busy     run in progress
//   ready    one-cycle completion pulse
//   rd_en    RAM read strobe, rd_addr = x + 5*y
//   rd_data  RAM read data, valid one cycle after rd_en
//   wr_en    RAM write strobe, wr_addr = x + 5*y, wr_data = computed lane
// -----------------------------------------------------------------------------
interface chi_step_if #(
    parameter int LANE_W = 64
);
    logic              start;
    logic              busy;
    logic              ready;
    logic              rd_en;
    logic [4:0]        rd_addr;
    logic [LANE_W-1:0] rd_data;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [LANE_W-1:0] wr_data;

    modport master (
        input  start, rd_data,
        output busy, ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data,
        input  busy, ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/chi_step.sv
// -----------------------------------------------------------------------------
// chi_step
//
// Keccak-f[1600] chi step. Transforms the 25-lane state held in an external
// synchronous state RAM in place, one plane (row of 5 lanes) at a time:
//   a'[x] = a[x] ^ (~a[(x+1) mod 5] & a[(x+2) mod 5])
// Each plane: 5 READ cycles, 1 CAP cycle (last read data), 5 WRITE cycles.
// The whole state takes 55 busy cycles; ready pulses in the following cycle.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-low reset
//   bus      chi_step_if.master (start/busy/ready handshake + RAM port)
//   run_cnt  (only with CHI_RUN_CNT_EN) 8-bit count of completed runs,
//            increments together with ready, wraps 255 -> 0
//
// Configuration macro: CHI_RUN_CNT_EN
//
// All outputs are registered except wr_data, which is decoded combinationally
// from the row buffer and the current lane counter.
// -----------------------------------------------------------------------------
module chi_step #(
    parameter int LANE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    chi_step_if.master        bus
`ifdef CHI_RUN_CNT_EN
    ,
    output logic [7:0]        run_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAP,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        cx;
    logic [2:0]        cy;
    logic [LANE_W-1:0] row [5];
    logic [LANE_W-1:0] chi_lane [5];

    function automatic logic [4:0] lane_addr(input logic [2:0] x, input logic [2:0] y);
        return 5'(x) + 5'(y) * 5'd5;
    endfunction

    // Chi over the buffered plane; the (x+1)/(x+2) indices wrap mod 5.
    always_comb begin
        for (int x = 0; x < 5; x++) begin
            chi_lane[x] = row[x] ^ (~row[(x + 1) % 5] & row[(x + 2) % 5]);
        end
    end

    // wr_data is driven only while writing so it reads zero at reset and idle.
    always_comb begin
        bus.wr_data = '0;
        if (state == WRITE) begin
            case (cx)
                3'd0:    bus.wr_data = chi_lane[0];
                3'd1:    bus.wr_data = chi_lane[1];
                3'd2:    bus.wr_data = chi_lane[2];
                3'd3:    bus.wr_data = chi_lane[3];
                3'd4:    bus.wr_data = chi_lane[4];
                default: bus.wr_data = '0;
            endcase
        end
    end

    // NOTE: the row buffer is only 5 lanes of flops, not a RAM macro, so it
    // is cleared on reset like every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.busy    <= 1'b0;
            bus.ready   <= 1'b0;
            for (int i = 0; i < 5; i++) row[i] <= '0;
`ifdef CHI_RUN_CNT_EN
            run_cnt     <= '0;
`endif
        end else begin
            // NOTE: all state here uses non-blocking assignment so every
            // register samples values from before this clock edge.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= READ;
                        cx          <= '0;
                        cy          <= '0;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= lane_addr(3'd0, 3'd0);
                        bus.busy    <= 1'b1;
                    end
                end

                READ: begin
                    // RAM data lags the address by one cycle, so this cycle's
                    // rd_data belongs to the previous lane.
                    if (cx != 3'd0) row[cx - 3'd1] <= bus.rd_data;
                    if (cx == 3'd4) begin
                        state     <= CAP;
                        bus.rd_en <= 1'b0;
                    end else begin
                        cx          <= cx + 3'd1;
                        bus.rd_addr <= lane_addr(cx + 3'd1, cy);
                    end
                end

                CAP: begin
                    row[4]      <= bus.rd_data;
                    state       <= WRITE;
                    cx          <= '0;
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= lane_addr(3'd0, cy);
                end

                WRITE: begin
                    if (cx == 3'd4) begin
                        bus.wr_en <= 1'b0;
                        if (cy == 3'd4) begin
                            state     <= DONE;
                            bus.busy  <= 1'b0;
                            bus.ready <= 1'b1;
`ifdef CHI_RUN_CNT_EN
                            run_cnt   <= run_cnt + 8'd1;
`endif
                        end else begin
                            state       <= READ;
                            cx          <= '0;
                            cy          <= cy + 3'd1;
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= lane_addr(3'd0, cy + 3'd1);
                        end
                    end else begin
                        cx          <= cx + 3'd1;
                        bus.wr_addr <= lane_addr(cx + 3'd1, cy);
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    bus.ready <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
